// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal reorder buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bitrev_pkg;

    localparam int DEF_LOG2N = 9;
    localparam int DEF_DW    = 32;
    // Widest frame index the reversal helper handles; LOG2N must stay below this.
    localparam int MAX_LOG2N = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v,
                                                    input int w);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            if (i < w) begin
                r = r | (((v >> (w - 1 - i)) & MAX_LOG2N'(1)) << i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_dpram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Latency: read data valid 1 cycle after re; re low holds rdata.
// Backpressure: none; caller gates re to stall the read pipe.
module bitrev_dpram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    // Storage is never reset so it maps onto block RAM.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port plus registered read port with read enable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Captures one N-sample frame in natural order, drains it bit-reversed or natural.
// Latency: first out_valid 2 cycles after drain entry, then 1 sample/clock.
// Backpressure: in_ready only while loading; out_ready low holds the output stage.
module bitrev_reorder_buffer
    import bitrev_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N,
    parameter int DW    = DEF_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode_bitrev,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    state_t                 state_q, state_d;
    logic [LOG2N-1:0]       wr_cnt, rd_cnt, rd_addr, rev_addr;
    logic [MAX_LOG2N-LOG2N-1:0] rev_unused;
    logic [MAX_LOG2N-1:0]   rd_cnt_ext;
    logic                   mode_q;
    logic                   rd_all;      // every address of the frame has been read
    logic                   pend_vld;    // RAM output holds a sample not yet staged
    logic [LOG2N-1:0]       pend_idx;
    logic                   pend_last;
    logic [DW-1:0]          ram_q;
    logic                   wr_en, out_acc, stage_load, rd_issue;

    assign wr_en      = (state_q == ST_LOAD) && in_valid;
    assign out_acc    = out_valid && out_ready;
    // Output stage refills when empty or when its sample leaves this cycle.
    assign stage_load = pend_vld && (!out_valid || out_ready);
    // A new read may only overwrite the RAM output once it has been staged.
    assign rd_issue   = (state_q == ST_DRAIN) && !rd_all && (!pend_vld || stage_load);

    assign rd_cnt_ext = {{(MAX_LOG2N-LOG2N){1'b0}}, rd_cnt};
    assign {rev_unused, rev_addr} = bitrev(rd_cnt_ext, LOG2N);
    assign rd_addr    = mode_q ? rev_addr : rd_cnt;

    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    bitrev_dpram #(.AW(LOG2N), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_cnt),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (wr_en && (wr_cnt == LAST_IDX)) state_d = ST_DRAIN;
            ST_DRAIN: if (out_acc && out_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write/read counters, latched mode and the in-flight read tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            mode_q    <= 1'b0;
            rd_all    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_idx  <= '0;
            pend_last <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                wr_cnt <= '0;
                mode_q <= mode_bitrev;
            end
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    rd_cnt <= '0;
                    rd_all <= 1'b0;
                end
            end
            if (rd_issue) begin
                rd_cnt    <= rd_cnt + 1'b1;
                rd_all    <= (rd_cnt == LAST_IDX);
                pend_idx  <= rd_addr;
                pend_last <= (rd_cnt == LAST_IDX);
            end
            if (rd_issue) begin
                pend_vld <= 1'b1;
            end else if (stage_load) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Registered output stage; holds its sample while out_ready is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (stage_load) begin
            out_valid <= 1'b1;
            out_data  <= ram_q;
            out_index <= pend_idx;
            out_last  <= pend_last;
        end else if (out_acc) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: doc/bitrev_reorder_buffer.md
Name: bitrev_reorder_buffer

Overview:
Parametrised bit-reversal reorder buffer for the spectrum analyzer's FFT path; it generalises the fixed 512-point bit-reverse-order test unit.
- Captures one frame of N = 2^LOG2N samples in natural order.
- Drains the frame either bit-reversed (mode_bitrev=1) or natural (mode_bitrev=0).
- Uses valid/ready handshakes on both sides and a single-cycle done pulse per frame.
- Sits between the sample capture front end and the FFT butterfly engine.

Parameters:
LOG2N, 9, log2 of frame length (N=512 default); legal range 2..12
DW, 32, sample width in bits (packed {re[DW/2-1:0], im[DW/2-1:0]}, treated opaquely)

Ports:
Clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle frame start request; honoured only in IDLE
mode_bitrev  in  1  read-order select, latched on accepted start
in_valid  in  1  input sample valid
in_ready  out  1  high only in LOAD
in_data  in  DW  input sample
out_valid  out  1  out_data holds a valid sample
out_ready  in  1  downstream accepts the sample
out_data  out  DW  reordered sample
out_index  out  LOG2N  natural write index of the sample on out_data
out_last  out  1  high with the final sample of the frame
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last sample is accepted

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; counters 0; latched mode 0; RAM contents are not cleared.
- States are IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD next cycle; wr_cnt=0; mode_bitrev is latched.
  - in_valid is ignored.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 writes in_data to mem[wr_cnt], then wr_cnt+1.
  - A write at wr_cnt==N-1 -> DRAIN; rd_cnt=0.
  - start is ignored. Cycles with in_valid=0 are stalls; no timeout.
- DRAIN:
  - Read address = latched mode ? bitrev(rd_cnt) : rd_cnt, where bitrev reverses all LOG2N bits.
  - RAM read is synchronous with 1-cycle latency. out_data, out_index and out_last come from a registered output stage.
  - A read issues when the output stage is empty, or full and accepted this cycle (out_valid & out_ready). Sustained throughput is therefore 1 sample/clock with out_ready held high.
  - First out_valid appears 2 cycles after DRAIN entry.
  - out_valid is held and out_data stays stable while out_ready=0.
  - out_index = the read address used.
  - out_last=1 only for the sample read at rd_cnt==N-1.
  - Acceptance of the out_last sample -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in this cycle is ignored.
- Simultaneous events:
  - A start asserted in the same cycle the frame completes is dropped. The source must re-issue it in IDLE.
  - Write and read never overlap, because frames are single-buffered.
- Counter wrap: wr_cnt and rd_cnt are LOG2N bits wide. Terminal detection uses ==N-1, not overflow.
- Reset mid-frame aborts the frame:
  - No done pulse.
  - Partial data is discarded logically.
  - The next frame starts from index 0.

Decomposition:
- Shared package bitrev_pkg:
  - state encoding (IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2, DONE=2'd3)
  - bitrev function parametrised on LOG2N
  - default LOG2N/DW constants
- One sub-module, bitrev_dpram:
  - simple dual-port sync RAM, depth 2^LOG2N, width DW
  - one write port, one registered read port
  - no reset on storage, so it infers block RAM
- FSM, counters and output stage live in the top module.

Test Plan:
1. Bitrev order, LOG2N=3, mode_bitrev=1, in_data=0..7 with in_valid held high, out_ready=1 -> out_data sequence 0,4,2,6,1,5,3,7; out_index matches; out_last only on 7; done pulses once, one cycle after that acceptance.
2. Natural order, LOG2N=3, mode_bitrev=0, in_data=10..17 -> outputs 10..17 in order; busy low again 1 cycle after done.
3. Backpressure, default 512-point bitrev frame, in_data=index, out_ready toggled 1-0-1-0 -> out_data stable during every out_ready=0 cycle; second accepted value is 256; all 512 values each seen exactly once.
4. Input stalls plus ignored start: in_valid gaps of 3 cycles during LOAD, and start pulsed mid-LOAD -> no extra frame; wr_cnt advances only on in_valid; output order unchanged.
5. Reset mid-DRAIN after 100 samples accepted -> all outputs 0 immediately (asynchronous), no done pulse; the following full frame drains correctly starting at out_index 0.
6. Back-to-back frames: start issued the cycle after done, mode_bitrev 1 then 0 -> second frame follows its own latched mode with no data carry-over or index error.
